serial_result_tx: RTL

Transmits one classification result from the FPGA to the Arduino over a two-wire clocked serial link. This is the return direction of the link that loads pixels into inputShiftRegister.
- Captures maxIndex and the full NNout vector on a start pulse.
- Frames them with a header byte and an XOR checksum byte.
- Shifts the frame out MSB-first on serialClock/serialData, with an active-low frame strobe.
- Sits beside the NeuralNetwork instance in top; the control FSM pulses start when maxValid fires.

---
 rtl/nn_serial_pkg.sv | 19 +
 rtl/serial_half_period_timer.sv | 35 +++
 rtl/serial_result_tx.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/nn_serial_pkg.sv
// Shared definitions for the FPGA-to-Arduino result link: frame header,
// transmitter state encoding and frame-length helper.
package nn_serial_pkg;

  localparam logic [7:0] FRAME_HEADER = 8'hA5;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    TRAIL
  } tx_state_t;

  // Header byte + index byte + checksum byte + all output words.
  function automatic int frame_bits(input int num_outputs, input int data_width);
    return 24 + num_outputs * data_width;
  endfunction

endpackage

// File: rtl/serial_half_period_timer.sv
// Counts clk cycles 0..clkDiv-1 for one serialClock half-period; terminal
// is high on the last cycle of the period, clear restarts the count.
module serial_half_period_timer #(
  parameter int clkDiv = 25
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  output logic terminal
);

  localparam int CW = (clkDiv > 1) ? $clog2(clkDiv) : 1;
  localparam logic [CW-1:0] LAST = CW'(clkDiv - 1);

  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;

  assign terminal = (count_reg == LAST);

  always_comb begin
    count_next = count_reg + CW'(1);
    if (clear || terminal) begin
      count_next = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/serial_result_tx.sv
// Sends one classification result (header, index, output words, XOR checksum)
// MSB-first over a clocked two-wire link with an active-low frame strobe.
module serial_result_tx
  import nn_serial_pkg::*;
#(
  parameter int dataWidth  = 16,
  parameter int numOutputs = 10,
  parameter int indexWidth = 4,
  parameter int clkDiv     = 25
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            start,
  input  logic [indexWidth-1:0]           maxIndex,
  input  logic [numOutputs*dataWidth-1:0] NNout,
  output logic                            busy,
  output logic                            done,
  output logic                            serialClock,
  output logic                            serialData,
  output logic                            frameN
);

  localparam int FRAME_BITS = frame_bits(numOutputs, dataWidth);
  localparam int BODY_BITS  = FRAME_BITS - 8;
  localparam int BODY_BYTES = BODY_BITS / 8;
  localparam int BCW        = $clog2(FRAME_BITS);

  // Everything except the checksum, in transmission order from the MSB down.
  logic [BODY_BITS-1:0]  body;
  logic [7:0]            checksum;
  logic [FRAME_BITS-1:0] frame;

  assign body[BODY_BITS-1 -: 8] = FRAME_HEADER;
  assign body[BODY_BITS-9 -: 8] = 8'(maxIndex);

  generate
    for (genvar gi = 0; gi < numOutputs; gi++) begin : g_words
      assign body[(numOutputs-1-gi)*dataWidth +: dataWidth] = NNout[gi*dataWidth +: dataWidth];
    end
  endgenerate

  always_comb begin
    checksum = '0;
    for (int i = 0; i < BODY_BYTES; i++) begin
      checksum = checksum ^ body[i*8 +: 8];
    end
  end

  assign frame = {body, checksum};

  tx_state_t             state_reg, state_next;
  logic [FRAME_BITS-1:0] shift_reg, shift_next;
  logic [BCW-1:0]        bit_cnt_reg, bit_cnt_next;
  logic                  busy_reg, busy_next;
  logic                  done_reg, done_next;
  logic                  sclk_reg, sclk_next;
  logic                  sdata_reg, sdata_next;
  logic                  frame_n_reg, frame_n_next;
  logic                  timer_clear;
  logic                  tick;

  serial_half_period_timer #(
    .clkDiv(clkDiv)
  ) u_timer (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (timer_clear),
    .terminal(tick)
  );

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    sclk_next    = sclk_reg;
    sdata_next   = sdata_reg;
    frame_n_next = frame_n_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next   = LOW;
          shift_next   = frame;
          bit_cnt_next = '0;
          busy_next    = 1'b1;
          sclk_next    = 1'b0;
          sdata_next   = frame[FRAME_BITS-1];
          frame_n_next = 1'b0;
        end
      end
      LOW: begin
        if (tick) begin
          state_next = HIGH;
          sclk_next  = 1'b1;
        end
      end
      HIGH: begin
        if (tick) begin
          sclk_next = 1'b0;
          if (bit_cnt_reg == BCW'(FRAME_BITS - 1)) begin
            state_next = TRAIL;
          end else begin
            // Next bit goes out on the same edge that drops serialClock.
            state_next   = LOW;
            shift_next   = shift_reg << 1;
            bit_cnt_next = bit_cnt_reg + BCW'(1);
            sdata_next   = shift_reg[FRAME_BITS-2];
          end
        end
      end
      TRAIL: begin
        if (tick) begin
          state_next   = IDLE;
          busy_next    = 1'b0;
          done_next    = 1'b1;
          sdata_next   = 1'b0;
          frame_n_next = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    timer_clear = (state_reg == IDLE) || (state_next != state_reg);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      sclk_reg    <= 1'b0;
      sdata_reg   <= 1'b0;
      frame_n_reg <= 1'b1;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      bit_cnt_reg <= bit_cnt_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      sclk_reg    <= sclk_next;
      sdata_reg   <= sdata_next;
      frame_n_reg <= frame_n_next;
    end
  end

  assign busy        = busy_reg;
  assign done        = done_reg;
  assign serialClock = sclk_reg;
  assign serialData  = sdata_reg;
  assign frameN      = frame_n_reg;

endmodule
